wavegen_sequencer: RTL
======================

WAVEGEN_SEQUENCER -- requirements
Module: wavegen_sequencer

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 200, meaning clk cycles per sample frame (minimum 40).
REQ-002 SHALL have parameter PIPE_LAT, default 4, meaning clk cycles from sample_en to valid sample_a/sample_b.
REQ-003 SHALL have port clk, input, 1, the single system clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port run, input, 2, per-channel run level ([0]=A, [1]=B).
REQ-006 SHALL have ports cycles_a and cycles_b, input, 16 each, burst period count; 0 means continuous.
REQ-007 SHALL have ports wrap_a and wrap_b, input, 1 each, datapath phase-wrap flags, sampled only in WAIT_PIPE's final cycle.
REQ-008 SHALL have ports sample_a and sample_b, input, 12 each, unsigned datapath samples.
REQ-009 SHALL have port sample_en, output, 1, one-cycle datapath advance strobe.
REQ-010 SHALL have ports dac_valid (output, 1), dac_ready (input, 1), dac_chan (output, 1), dac_data (output, 12), forming the serializer handshake.
REQ-011 SHALL have port ldac_req, output, 1, one-cycle latch request after both channels transfer.
REQ-012 SHALL have ports active (output, 2), done (output, 2, one-cycle pulses), overrun (output, 1), overrun_cnt (output, 8).

Function
REQ-013 SHALL count a frame divider 0..SAMPLE_DIV-1 continuously; terminal count raises a frame tick.
REQ-014 SHALL implement FSM IDLE -> TICK -> WAIT_PIPE -> SEND_A -> SEND_B -> LATCH -> IDLE.
REQ-015 IDLE: on frame tick with any active bit set, go to TICK; otherwise stay, no outputs asserted.
REQ-016 TICK: assert sample_en for exactly one cycle, then enter WAIT_PIPE.
REQ-017 WAIT_PIPE: hold PIPE_LAT cycles, capture sample_a/sample_b/wrap_a/wrap_b in the last cycle.
REQ-018 SEND_A/SEND_B: assert dac_valid with dac_chan 0/1; data, chan stable while valid and !ready; transfer when valid && ready; advance next cycle.
REQ-019 An inactive channel SHALL send 12'h800 (midscale) instead of its captured sample.
REQ-020 LATCH: assert ldac_req one cycle, return to IDLE.
REQ-021 Rising edge of run[i] SHALL set active[i] and load its remaining-count from cycles_x in the same cycle.
REQ-022 Falling edge of run[i] SHALL clear active[i] immediately without done pulse; an in-progress frame completes with midscale for that channel.
REQ-023 Captured wrap on an active channel with nonzero cycles SHALL decrement remaining-count; at 1->0 clear active[i] and pulse done[i] in LATCH.
REQ-024 cycles_x = 0 SHALL never decrement or terminate.
REQ-025 Frame tick while FSM not in IDLE SHALL be an overrun: tick discarded, frame not restarted.
REQ-026 Simultaneous run edge and captured wrap SHALL give priority to the run edge (reload wins).

Reset
REQ-027 On reset low: FSM IDLE, divider 0, active 0, remaining-counts 0, all outputs 0, dac_data 0.
REQ-028 Reset mid-transfer SHALL drop dac_valid asynchronously; no ldac_req follows.

Configuration
REQ-029 Macro WAVEGEN_SEQ_OVERRUN_EN defined: overrun is sticky until reset, overrun_cnt saturates at 255.
REQ-030 Macro undefined: overrun and overrun_cnt tied 0; discard behaviour of REQ-025 unchanged.

Structure
REQ-031 Package wavegen_pkg SHALL hold the FSM state enum, DAC_MIDSCALE=12'h800, CH_A=0/CH_B=1, sample width 12.
REQ-032 Sub-module frame_tick_gen SHALL implement the REQ-013 divider; everything else in wavegen_sequencer.

Verification
REQ-033 run=2'b11, cycles 0, dac_ready=1 -> per frame one sample_en, A then B transfer, one ldac_req, PIPE_LAT+4 cycles after tick.
REQ-034 run=2'b01, sample_a=12'h3FF -> SEND_A 12'h3FF, SEND_B 12'h800.
REQ-035 cycles_a=3, wrap_a every 2nd frame -> done[0] pulse in 6th frame LATCH, active[0]=0 after, no further sample_en if B inactive.
REQ-036 dac_ready held low 300 cycles in SEND_A, SAMPLE_DIV=200 -> dac_data stable, overrun=1, overrun_cnt=1 (macro on) / 0 (macro off).
REQ-037 reset low during SEND_B -> dac_valid 0 same cycle, no ldac_req; after release first sample_en one frame later.
REQ-038 run[1] falls during WAIT_PIPE -> frame completes with B=12'h800, done[1] stays 0.

Source files
------------

// File: rtl/wavegen_pkg.sv
// Shared types and constants for the two-channel waveform DAC sequencer.
package wavegen_pkg;

  localparam int SAMPLE_W = 12;
  localparam logic [SAMPLE_W-1:0] DAC_MIDSCALE = 12'h800;
  localparam int CH_A = 0;
  localparam int CH_B = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TICK,
    ST_WAIT_PIPE,
    ST_SEND_A,
    ST_SEND_B,
    ST_LATCH
  } seq_state_t;

  // A channel that is not running parks the DAC at midscale.
  function automatic logic [SAMPLE_W-1:0] chan_value(input logic en,
                                                     input logic [SAMPLE_W-1:0] s);
    return en ? s : DAC_MIDSCALE;
  endfunction

endpackage

// File: rtl/wavegen_sequencer_frame_tick_gen.sv
// Free-running frame divider: counts 0..SAMPLE_DIV-1 and flags the terminal count.
module frame_tick_gen #(
  parameter int SAMPLE_DIV = 200
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(SAMPLE_DIV);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == CW'(SAMPLE_DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = (div_cnt == CW'(SAMPLE_DIV - 1));

endmodule

// File: rtl/wavegen_sequencer.sv
// Two-channel waveform sequencer: frames datapath samples into a DAC serializer.
// Optional sticky overrun reporting is built when WAVEGEN_SEQ_OVERRUN_EN is defined.
module wavegen_sequencer
  import wavegen_pkg::*;
#(
  parameter int SAMPLE_DIV = 200,
  parameter int PIPE_LAT   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          run,
  input  logic [15:0]         cycles_a,
  input  logic [15:0]         cycles_b,
  input  logic                wrap_a,
  input  logic                wrap_b,
  input  logic [SAMPLE_W-1:0] sample_a,
  input  logic [SAMPLE_W-1:0] sample_b,
  output logic                sample_en,
  output logic                dac_valid,
  input  logic                dac_ready,
  output logic                dac_chan,
  output logic [SAMPLE_W-1:0] dac_data,
  output logic                ldac_req,
  output logic [1:0]          active,
  output logic [1:0]          done,
  output logic                overrun,
  output logic [7:0]          overrun_cnt
);

  localparam int PW = $clog2(PIPE_LAT + 1);

  seq_state_t state, state_next;
  logic       frame_tick;
  logic [1:0] run_q, run_rise, run_fall;
  logic [PW-1:0] pipe_cnt;
  logic       pipe_last;
  logic [1:0] done_pend;

  logic [1:0][15:0]         cycles_v;
  logic [1:0]               wrap_v;
  logic [1:0][SAMPLE_W-1:0] sample_v;
  logic [1:0][SAMPLE_W-1:0] cap_data;

  assign cycles_v = {cycles_b, cycles_a};
  assign wrap_v   = {wrap_b, wrap_a};
  assign sample_v = {sample_b, sample_a};

  frame_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (frame_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q <= 2'b00;
    end else begin
      run_q <= run;
    end
  end

  assign run_rise = run & ~run_q;
  assign run_fall = ~run & run_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (frame_tick && (|active)) state_next = ST_TICK;
      ST_TICK:      state_next = ST_WAIT_PIPE;
      ST_WAIT_PIPE: if (pipe_last) state_next = ST_SEND_A;
      ST_SEND_A:    if (dac_ready) state_next = ST_SEND_B;
      ST_SEND_B:    if (dac_ready) state_next = ST_LATCH;
      ST_LATCH:     state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Outputs decode straight from the state register so reset drops them at once.
  always_comb begin
    sample_en = (state == ST_TICK);
    dac_valid = (state == ST_SEND_A) || (state == ST_SEND_B);
    dac_chan  = (state == ST_SEND_B);
    ldac_req  = (state == ST_LATCH);
    dac_data  = '0;
    if (state == ST_SEND_A) dac_data = cap_data[CH_A];
    if (state == ST_SEND_B) dac_data = cap_data[CH_B];
    done = (state == ST_LATCH) ? (done_pend & ~run_rise) : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_cnt <= '0;
    end else if (state == ST_WAIT_PIPE) begin
      pipe_cnt <= pipe_cnt + 1'b1;
    end else begin
      pipe_cnt <= '0;
    end
  end

  assign pipe_last = (state == ST_WAIT_PIPE) && (pipe_cnt == PW'(PIPE_LAT - 1));

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic                act_q;
      logic                pend_q;
      logic [15:0]         rem_q;
      logic [SAMPLE_W-1:0] cap_q;
      logic                hold_cap;

      // Once this channel's word is on the bus it must not change under a stall.
      assign hold_cap = (state == ((gi == CH_A) ? ST_SEND_A : ST_SEND_B));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          act_q  <= 1'b0;
          pend_q <= 1'b0;
          rem_q  <= '0;
          cap_q  <= '0;
        end else begin
          if (pipe_last) begin
            cap_q <= chan_value(act_q & ~run_fall[gi], sample_v[gi]);
          end else if (run_fall[gi] && !hold_cap) begin
            cap_q <= DAC_MIDSCALE;
          end

          // Run edges override any wrap captured in the same cycle.
          if (run_rise[gi]) begin
            act_q  <= 1'b1;
            rem_q  <= cycles_v[gi];
            pend_q <= 1'b0;
          end else if (run_fall[gi]) begin
            act_q  <= 1'b0;
            pend_q <= 1'b0;
          end else if (pipe_last && act_q && wrap_v[gi] && (rem_q != 16'd0)) begin
            rem_q <= rem_q - 16'd1;
            if (rem_q == 16'd1) pend_q <= 1'b1;
          end else if ((state == ST_LATCH) && pend_q) begin
            act_q  <= 1'b0;
            pend_q <= 1'b0;
          end
        end
      end

      assign active[gi]    = act_q;
      assign done_pend[gi] = pend_q;
      assign cap_data[gi]  = cap_q;
    end
  endgenerate

`ifdef WAVEGEN_SEQ_OVERRUN_EN
  logic       ovr_q;
  logic [7:0] ovr_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_q     <= 1'b0;
      ovr_cnt_q <= 8'd0;
    end else if (frame_tick && (state != ST_IDLE)) begin
      ovr_q <= 1'b1;
      if (ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
    end
  end

  assign overrun     = ovr_q;
  assign overrun_cnt = ovr_cnt_q;
`else
  assign overrun     = 1'b0;
  assign overrun_cnt = 8'd0;
`endif

endmodule
